// File: rtl/decoder_3to8.sv
// Registered binary-to-one-hot decoder.
// A code on x selects bit y[x]; the result, a valid flag and an unknown-code
// flag are registered on clk and cleared asynchronously by rst_n.
module decoder_3to8 #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             valid,
    output logic             err
);

    // OUT_W is derived from IN_W; reject out-of-range or overridden widths.
    generate
        if (IN_W < 1 || IN_W > 6 || OUT_W != 2 ** IN_W) begin : g_bad_param
            $error("decoder_3to8: IN_W must be 1..6 and OUT_W must equal 2**IN_W");
        end
    endgenerate

    logic [OUT_W-1:0] y_d;
    logic             valid_d;
    logic             err_d;
    logic             hit;

    // Next-state decode. A code holding X/Z bits matches no k, so hit stays 0
    // and err is raised; with two-state logic hit is always 1 and err folds to 0.
    always_comb begin
        y_d = '0;
        hit = 1'b0;
        for (int k = 0; k < OUT_W; k++) begin
            if (x == IN_W'(k)) begin
                y_d[k] = 1'b1;
                hit    = 1'b1;
            end
        end
        if (!en) begin
            y_d     = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            valid_d = hit;
            err_d   = !hit;
        end
    end

    // Output registers; reset clears everything without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            y     <= y_d;
            valid <= valid_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8.
// Inputs are driven on the falling edge; outputs are sampled #1 after the rising edge.
module tb_decoder_3to8;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       en;
    logic [2:0] x;
    logic [7:0] y;
    logic       valid;
    logic       err;

    int total;
    int bad;

    // Hand-computed one-hot table for codes 0..7.
    logic [7:0] exp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x     (x),
        .y     (y),
        .valid (valid),
        .err   (err)
    );

    // Gated free-running clock so it can be stopped for the async-reset check.
    always #5 if (clk_run) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        x     = 3'b101;
        tick();
        tick();
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (y !== 8'h20 || valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_decode: got y=%h valid=%b err=%b, want y=20 valid=1 err=0",
                     y, valid, err);
        end
        // Stop the clock low, then assert reset: outputs must clear with no edge.
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
        #4;
        rst_n = 1'b1;
        #3;
        clk_run = 1'b1;
    endtask

    task automatic test_sweep();
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            x = 3'(k);
            // Odd codes are held for two cycles.
            for (int h = 0; h < ((k % 2) + 1); h++) begin
                tick();
                total++;
                if (y !== exp_tab[k] || valid !== 1'b1 || err !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep_x%0d: got y=%h valid=%b err=%b, want y=%h valid=1 err=0",
                             k, y, valid, err, exp_tab[k]);
                end
            end
        end
    endtask

    task automatic test_unknown();
        logic [7:0] ey;
        logic       ev;
        logic       ee;
        @(negedge clk);
        en = 1'b1;
        x  = 3'bxxx;
        // A two-state simulator cannot hold X; expect a plain decode there.
        if ($isunknown(x)) begin
            ey = 8'h00; ev = 1'b0; ee = 1'b1;
        end else begin
            ey = exp_tab[x]; ev = 1'b1; ee = 1'b0;
        end
        tick();
        total++;
        if (y !== ey || valid !== ev || err !== ee) begin
            bad++;
            $display("FAIL unknown_x: got y=%h valid=%b err=%b, want y=%h valid=%b err=%b",
                     y, valid, err, ey, ev, ee);
        end
        @(negedge clk);
        x = 3'b011;
        tick();
        total++;
        if (y !== 8'h08 || valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL unknown_recover: got y=%h valid=%b err=%b, want y=08 valid=1 err=0",
                     y, valid, err);
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        x  = 3'b110;
        en = 1'b0;
        tick();
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL enable_off: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
        @(negedge clk);
        en = 1'b1;
        tick();
        total++;
        if (y !== 8'h40 || valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL enable_on: got y=%h valid=%b err=%b, want y=40 valid=1 err=0",
                     y, valid, err);
        end
        @(negedge clk);
        en = 1'b0;
        tick();
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL enable_drop: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
        // Unknown code while disabled must not raise err.
        @(negedge clk);
        x = 3'bx0x;
        tick();
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL enable_off_unknown: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        en = 1'b1;
        x  = 3'd2;
        tick();
        total++;
        if (y !== 8'h04 || valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_x2: got y=%h valid=%b, want y=04 valid=1", y, valid);
        end
        @(negedge clk);
        x = 3'd3;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (y !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_clear: got y=%h valid=%b err=%b, want y=00 valid=0 err=0",
                     y, valid, err);
        end
        #1;
        rst_n = 1'b1;
        x     = 3'd4;
        tick();
        total++;
        if (y !== 8'h10 || valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_after_release: got y=%h valid=%b err=%b, want y=10 valid=1 err=0",
                     y, valid, err);
        end
    endtask

    task automatic test_invariants();
        logic [7:0] ey;
        logic       ev;
        logic       ee;
        int         inv_bad;
        int         mdl_bad;
        inv_bad = 0;
        mdl_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) x = 3'bx1x;
            else x = 3'($urandom_range(0, 7));
            if (!en) begin
                ey = 8'h00; ev = 1'b0; ee = 1'b0;
            end else if ($isunknown(x)) begin
                ey = 8'h00; ev = 1'b0; ee = 1'b1;
            end else begin
                ey = exp_tab[x]; ev = 1'b1; ee = 1'b0;
            end
            tick();
            if ((valid === 1'b1 && $countones(y) != 1) || (valid === 1'b0 && y !== 8'h00)
                || (valid === 1'b1 && err === 1'b1)) begin
                inv_bad++;
                if (inv_bad <= 5)
                    $display("FAIL invariant_c%0d: got y=%h valid=%b err=%b", c, y, valid, err);
            end
            if (y !== ey || valid !== ev || err !== ee) begin
                mdl_bad++;
                if (mdl_bad <= 5)
                    $display("FAIL random_c%0d: got y=%h valid=%b err=%b, want y=%h valid=%b err=%b",
                             c, y, valid, err, ey, ev, ee);
            end
        end
        total += 2;
        if (inv_bad != 0) bad++;
        if (mdl_bad != 0) bad++;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        clk     = 1'b0;
        clk_run = 1'b1;
        rst_n   = 1'b0;
        en      = 1'b0;
        x       = 3'd0;
        test_reset();
        test_sweep();
        test_unknown();
        test_enable();
        test_reset_mid();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
